// File: rtl/prescaler_multi.sv
// Multi-channel programmable clock prescaler: NCH independent dividers of clkin,
// each with a registered divided clock, a one-cycle tick, and glitch-free divisor reload.
module prescaler_multi #(
    parameter int NCH         = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                   clkin,
    input  logic                   rstn,
    input  logic [NCH-1:0]         en,
    input  logic                   sync,
    input  logic [NCH-1:0]         load,
    input  logic [NCH*WIDTH-1:0]   div,
    output logic [NCH-1:0]         clkout,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         pend
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    // Divisors 0 and 1 cannot produce a square wave; treat them as 2.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < TWO) ? TWO : d;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [WIDTH-1:0] cnt_reg, cnt_next;
            logic [WIDTH-1:0] act_reg, act_next;
            logic [WIDTH-1:0] pdiv_reg, pdiv_next;
            logic             pend_reg, pend_next;
            logic             clk_reg, clk_next;
            logic             tick_reg, tick_next;
            logic [WIDTH-1:0] div_slice;
            logic             wrap;

            assign div_slice = div[gi*WIDTH +: WIDTH];
            // act_reg is always >= 2, so D-1 never underflows.
            assign wrap      = (cnt_reg == act_reg - ONE);

            always_comb begin
                cnt_next  = cnt_reg;
                act_next  = act_reg;
                pdiv_next = pdiv_reg;
                pend_next = pend_reg;
                clk_next  = clk_reg;
                tick_next = 1'b0;

                // Disabled and sync share one behaviour: park at phase 0 and take any pending divisor.
                if (!en[gi] || sync) begin
                    cnt_next = '0;
                    clk_next = 1'b0;
                    if (pend_reg) begin
                        act_next  = pdiv_reg;
                        pend_next = 1'b0;
                    end
                end else begin
                    clk_next = (cnt_reg >= (act_reg >> 1));
                    if (wrap) begin
                        cnt_next  = '0;
                        tick_next = 1'b1;
                        if (pend_reg) begin
                            act_next  = pdiv_reg;
                            pend_next = 1'b0;
                        end
                    end else begin
                        cnt_next = cnt_reg + ONE;
                    end
                end

                // A load lands after the apply decision above, so it always waits for the next boundary.
                if (load[gi]) begin
                    pdiv_next = clamp_div(div_slice);
                    pend_next = 1'b1;
                end
            end

            always_ff @(posedge clkin or negedge rstn) begin
                if (!rstn) begin
                    cnt_reg  <= '0;
                    act_reg  <= DIV_RST;
                    pdiv_reg <= DIV_RST;
                    pend_reg <= 1'b0;
                    clk_reg  <= 1'b0;
                    tick_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    act_reg  <= act_next;
                    pdiv_reg <= pdiv_next;
                    pend_reg <= pend_next;
                    clk_reg  <= clk_next;
                    tick_reg <= tick_next;
                end
            end

            assign clkout[gi] = clk_reg;
            assign tick[gi]   = tick_reg;
            assign pend[gi]   = pend_reg;
        end
    endgenerate

endmodule
